// File: rtl/instr_fetch_sequencer_if.sv
// Instruction memory read bus between the fetch sequencer and instruction memory.
// Latency: none (wires only); the master holds mem_req/mem_addr until mem_ack.
// Backpressure: memory stalls a fetch by withholding mem_ack.
// Signals: mem_req/mem_addr (master->slave), mem_ack/mem_rdata (slave->master).
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetch sequencer: reads an instruction, loads the IR, pulses run low and waits for done.
// Latency: mem_ack cycle -> LOAD (ir_load) -> EXEC (run low), i.e. two cycles fetch-to-run.
// Backpressure: FETCH stalls on mem_ack (ERROR after ACK_TIMEOUT cycles); WAIT stalls on done.
// Ports: clk, reset (sync active-high), start/start_addr, mem (bus master modport),
//        ir_data/ir_load, run (active-low pulse), done, pc, instr_count, halted, err.
// Optional: define SINGLE_STEP_EN to add input step and a PAUSE state after each instruction.
module instr_fetch_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  instr_fetch_sequencer_if.master mem,
  output logic [15:0]             ir_data,
  output logic                    ir_load,
  output logic                    run,
  input  logic                    done,
  output logic [ADDR_W-1:0]       pc,
  output logic [15:0]             instr_count,
  output logic                    halted,
  output logic                    err
`ifdef SINGLE_STEP_EN
  ,
  input  logic                    step
`endif
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_WAIT,
    S_HALT,
    S_ERROR
`ifdef SINGLE_STEP_EN
    ,
    S_PAUSE
`endif
  } state_t;

  state_t            state;
  logic [TMO_W-1:0]  tmo;
  logic              mem_req_q;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir_data     <= '0;
      instr_count <= '0;
      tmo         <= '0;
      mem_req_q   <= 1'b0;
      ir_load     <= 1'b0;
      run         <= 1'b1;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      // ir_load and run are single-cycle strobes; only the entering transition sets them.
      ir_load <= 1'b0;
      run     <= 1'b1;
      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            pc          <= start_addr;
            instr_count <= '0;
            tmo         <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
            mem_req_q   <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          // An ack arriving on the final allowed cycle still wins over the timeout.
          if (mem.mem_ack) begin
            ir_data   <= mem.mem_rdata;
            tmo       <= '0;
            mem_req_q <= 1'b0;
            ir_load   <= 1'b1;
            state     <= S_LOAD;
          end else if (tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
            tmo       <= tmo + 1'b1;
            mem_req_q <= 1'b0;
            err       <= 1'b1;
            state     <= S_ERROR;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_LOAD: begin
          // All-ones instruction word is the halt marker; the control unit is never started.
          if (ir_data == 16'hFFFF) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            run   <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            pc <= pc + 1'b1;
            if (instr_count != 16'hFFFF) begin
              instr_count <= instr_count + 16'd1;
            end
`ifdef SINGLE_STEP_EN
            state <= S_PAUSE;
`else
            mem_req_q <= 1'b1;
            state     <= S_FETCH;
`endif
          end
        end
`ifdef SINGLE_STEP_EN
        S_PAUSE: begin
          if (step) begin
            mem_req_q <= 1'b1;
            state     <= S_FETCH;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic [15:0] ir_data;
  logic        ir_load;
  logic        run;
  logic        done;
  logic [7:0]  pc;
  logic [15:0] instr_count;
  logic        halted;
  logic        err;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch_sequencer_if #(.ADDR_W(8)) mem_if ();

  instr_fetch_sequencer #(.ADDR_W(8), .ACK_TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .mem         (mem_if),
    .ir_data     (ir_data),
    .ir_load     (ir_load),
    .run         (run),
    .done        (done),
    .pc          (pc),
    .instr_count (instr_count),
    .halted      (halted),
    .err         (err)
`ifdef SINGLE_STEP_EN
    ,
    .step        (step)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responds for one cycle; the returned word is queued as the expected IR content.
  task automatic fetch_ack(input logic [15:0] data);
    exp_q.push_back(data);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = data;
    tick();
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_addr = 8'h00; done = 1'b0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 16'h0000;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({mem_if.mem_req, ir_load, run, halted, err} !== 5'b00100) begin
      errors++; $display("FAIL reset_ctrl got %b required 00100", {mem_if.mem_req, ir_load, run, halted, err});
    end
    checks++;
    if ({pc, ir_data, instr_count} !== 40'h0) begin
      errors++; $display("FAIL reset_regs got %h required 0", {pc, ir_data, instr_count});
    end
    // reset wins over start
    reset = 1'b1; start = 1'b1; start_addr = 8'h33;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b0 || pc !== 8'h00) begin
      errors++; $display("FAIL reset_prio got req=%b pc=%h required req=0 pc=00", mem_if.mem_req, pc);
    end
  endtask

  task automatic test_basic_fetch();
    logic [15:0] exp;
    start = 1'b1; start_addr = 8'h10;
    tick();
    start = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 8'h10 || run !== 1'b1) begin
      errors++; $display("FAIL fetch_req got req=%b addr=%h run=%b required 1 10 1", mem_if.mem_req, mem_if.mem_addr, run);
    end
    fetch_ack(16'h4203);
    checks++;
    if (ir_load !== 1'b1 || mem_if.mem_req !== 1'b0 || run !== 1'b1) begin
      errors++; $display("FAIL load_cycle got ir_load=%b req=%b run=%b required 1 0 1", ir_load, mem_if.mem_req, run);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL basic_ir no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (ir_data !== exp) begin
        errors++; $display("FAIL basic_ir got %h required %h", ir_data, exp);
      end
    end
    tick();
    checks++;
    if (run !== 1'b0 || ir_load !== 1'b0 || mem_if.mem_req !== 1'b0) begin
      errors++; $display("FAIL exec_cycle got run=%b ir_load=%b req=%b required 0 0 0", run, ir_load, mem_if.mem_req);
    end
    tick();
    repeat (3) tick();
    checks++;
    if (run !== 1'b1 || mem_if.mem_req !== 1'b0 || pc !== 8'h10) begin
      errors++; $display("FAIL wait_hold got run=%b req=%b pc=%h required 1 0 10", run, mem_if.mem_req, pc);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (pc !== 8'h11 || instr_count !== 16'd1 || mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 8'h11) begin
      errors++; $display("FAIL retire got pc=%h cnt=%0d req=%b addr=%h required 11 1 1 11", pc, instr_count, mem_if.mem_req, mem_if.mem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; start_addr = 8'hFF;
    tick();
    start = 1'b0;
    fetch_ack(16'h0001);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL wrap_ir no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (ir_data !== exp || ir_load !== 1'b1) begin
        errors++; $display("FAIL wrap_ir got %h load=%b required %h 1", ir_data, ir_load, exp);
      end
    end
    tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (pc !== 8'h00 || mem_if.mem_addr !== 8'h00 || mem_if.mem_req !== 1'b1 || instr_count !== 16'd1) begin
      errors++; $display("FAIL pc_wrap got pc=%h addr=%h req=%b cnt=%0d required 00 00 1 1", pc, mem_if.mem_addr, mem_if.mem_req, instr_count);
    end
  endtask

  task automatic test_halt();
    logic [15:0] exp;
    int bad;
    fetch_ack(16'hFFFF);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL halt_ir no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (ir_data !== exp) begin
        errors++; $display("FAIL halt_ir got %h required %h", ir_data, exp);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || run !== 1'b1 || pc !== 8'h00 || instr_count !== 16'd1) begin
      errors++; $display("FAIL halt_state got halted=%b run=%b pc=%h cnt=%0d required 1 1 00 1", halted, run, pc, instr_count);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (run !== 1'b1 || mem_if.mem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_hold got %0d bad cycles required 0", bad);
    end
    start = 1'b1; start_addr = 8'h40;
    tick();
    start = 1'b0;
    checks++;
    if (halted !== 1'b0 || pc !== 8'h40 || instr_count !== 16'd0 || mem_if.mem_req !== 1'b1) begin
      errors++; $display("FAIL restart got halted=%b pc=%h cnt=%0d req=%b required 0 40 0 1", halted, pc, instr_count, mem_if.mem_req);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] exp;
    int n;
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++; $display("FAIL timeout_cycles got %0d required 15", n);
    end
    checks++;
    if (err !== 1'b1 || mem_if.mem_req !== 1'b0) begin
      errors++; $display("FAIL error_state got err=%b req=%b required 1 0", err, mem_if.mem_req);
    end
    // ack on the last allowed cycle beats the timeout
    start = 1'b1; start_addr = 8'h50;
    tick();
    start = 1'b0;
    repeat (14) tick();
    fetch_ack(16'h1234);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL ack_prio no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (err !== 1'b0 || ir_load !== 1'b1 || ir_data !== exp) begin
        errors++; $display("FAIL ack_prio got err=%b load=%b ir=%h required 0 1 %h", err, ir_load, ir_data, exp);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    tick(); tick();
    checks++;
    if (pc !== 8'h50 || run !== 1'b1) begin
      errors++; $display("FAIL pre_reset got pc=%h run=%b required 50 1", pc, run);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({mem_if.mem_req, ir_load, run, halted, err} !== 5'b00100 || {pc, ir_data, instr_count} !== 40'h0) begin
      errors++; $display("FAIL reset_wait got ctrl=%b regs=%h required 00100 0", {mem_if.mem_req, ir_load, run, halted, err}, {pc, ir_data, instr_count});
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    logic [15:0] exp;
    int bad;
    start = 1'b1; start_addr = 8'h20;
    tick();
    start = 1'b0;
    fetch_ack(16'h5555);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL step_ir no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (ir_data !== exp) begin
        errors++; $display("FAIL step_ir got %h required %h", ir_data, exp);
      end
    end
    tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_if.mem_req !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || pc !== 8'h21 || instr_count !== 16'd1) begin
      errors++; $display("FAIL pause got bad=%0d pc=%h cnt=%0d required 0 21 1", bad, pc, instr_count);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 8'h21) begin
      errors++; $display("FAIL step_resume got req=%b addr=%h required 1 21", mem_if.mem_req, mem_if.mem_addr);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_wrap();
    test_halt();
    test_timeout();
    test_reset_mid_wait();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the program counter and memory address width.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum number of FETCH cycles without mem_ack before ERROR.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, which begins execution at start_addr.
REQ-006 The block SHALL have port start_addr, input, ADDR_W, the initial PC.
REQ-007 The block SHALL have port mem_req, output, 1, the instruction memory read request.
REQ-008 The block SHALL have port mem_addr, output, ADDR_W, the read address (equal to pc).
REQ-009 The block SHALL have port mem_ack, input, 1, meaning mem_rdata is valid this cycle.
REQ-010 The block SHALL have port mem_rdata, input, 16, the instruction word.
REQ-011 The block SHALL have port ir_data, output, 16, the latched instruction for the processor IR.
REQ-012 The block SHALL have port ir_load, output, 1, a one-cycle IR write strobe.
REQ-013 The block SHALL have port run, output, 1, active-low, driven low for one cycle to start the control unit at T0.
REQ-014 The block SHALL have port done, input, 1, the instruction-complete flag from the control unit.
REQ-015 The block SHALL have port pc, output, ADDR_W, the current program counter.
REQ-016 The block SHALL have port instr_count, output, 16, the count of retired instructions.
REQ-017 The block SHALL have port halted, output, 1, high in HALT.
REQ-018 The block SHALL have port err, output, 1, high in ERROR.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, LOAD, EXEC, WAIT, HALT and ERROR, one transition per clk.
REQ-020 In IDLE, HALT or ERROR, start=1 SHALL load pc<=start_addr, clear instr_count and the timeout counter, and enter FETCH; in all other states start is ignored.
REQ-021 In FETCH, mem_req=1 and mem_addr=pc; on mem_ack=1 the block SHALL latch ir_data<=mem_rdata and enter LOAD.
REQ-022 A timeout counter SHALL increment each FETCH cycle with mem_ack=0; on reaching ACK_TIMEOUT it SHALL enter ERROR; mem_ack in that same cycle SHALL take priority.
REQ-023 In LOAD, ir_load=1 for exactly one cycle; if ir_data==16'hFFFF the block SHALL enter HALT and not issue run; otherwise it SHALL enter EXEC.
REQ-024 In EXEC, run=0 for exactly one cycle, then the block SHALL enter WAIT; done is ignored in EXEC.
REQ-025 In WAIT, on done=1 the block SHALL set pc<=pc+1 modulo 2^ADDR_W (all-ones wraps to 0), increment instr_count saturating at 16'hFFFF, and enter FETCH; done=0 holds WAIT indefinitely.
REQ-026 Fetch-to-run latency SHALL be 2 cycles: the mem_ack cycle, then LOAD, then EXEC with run=0.
REQ-027 mem_req, ir_load and run(low) SHALL never be asserted in the same cycle.

Reset
REQ-028 reset=1 at any edge, including mid-fetch or mid-WAIT, SHALL force IDLE, pc=0, ir_data=0, instr_count=0, timeout=0, mem_req=0, ir_load=0, run=1, halted=0, err=0; reset SHALL take priority over start.

Configuration
REQ-029 With SINGLE_STEP_EN defined, the block SHALL add input step (1 bit) and a PAUSE state: in WAIT, done=1 updates pc and count and enters PAUSE; PAUSE enters FETCH on a cycle with step=1.
REQ-030 Without SINGLE_STEP_EN, the step port and PAUSE state SHALL not exist, and WAIT goes directly to FETCH.

Verification
REQ-031 reset; start=1 with start_addr=8'h10; mem_ack=1 with 16'h4203 on cycle 2 -> ir_load on cycle 3, run=0 on cycle 4, mem_addr=8'h10.
REQ-032 After REQ-031, done=1 in WAIT -> pc=8'h11, instr_count=1, mem_req=1 on the next cycle.
REQ-033 pc=8'hFF with done -> pc=8'h00 and the next fetch is from address 0.
REQ-034 mem_rdata=16'hFFFF -> halted=1, run stays 1, pc unchanged; start=1 restarts from start_addr.
REQ-035 mem_ack held 0 in FETCH -> err=1 after 15 cycles; reset=1 asserted mid-WAIT -> all outputs at reset values on the next cycle.
REQ-036 With SINGLE_STEP_EN defined, done -> PAUSE with no mem_req for 5 cycles; step=1 -> mem_req=1 on the next cycle.
